// File: rtl/grant_lock_pkg.sv
// Shared types and default constants for the grant-lock stage.
package grant_lock_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_PORTS_DEF = 5;
    localparam int MAX_HOLD_DEF  = 16;

endpackage : grant_lock_pkg

// File: rtl/grant_lock_ctrl_onehot_to_idx.sv
// onehot_to_idx: isolates the lowest set bit of a vector and encodes its
// position in binary. A zero input gives a zero mask and a zero index.
module onehot_to_idx #(
    parameter int N = 5
) (
    input  logic [N-1:0]         in_i,
    output logic [N-1:0]         mask_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N);

    // Bit gi survives only when no lower bit is set, so mask_o is one-hot or zero.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            if (gi == 0) begin : g_first
                assign mask_o[gi] = in_i[gi];
            end else begin : g_rest
                assign mask_o[gi] = in_i[gi] & ~(|in_i[gi-1:0]);
            end
        end
    endgenerate

    // Binary encode of the isolated bit; at most one term contributes.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (mask_o[i]) begin
                idx_o = idx_o | IDX_W'(i);
            end
        end
    end

endmodule : onehot_to_idx

// File: rtl/grant_lock_ctrl.sv
// grant_lock_ctrl: registers the fixed-priority arbiter's grant and locks it to
// the winning port until that port drops its request or pulses done.
// Optional forced release after max_hold cycles is enabled by GNT_TIMEOUT_EN.
module grant_lock_ctrl
    import grant_lock_pkg::*;
#(
    parameter int num_ports = NUM_PORTS_DEF,
    parameter int max_hold  = MAX_HOLD_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [num_ports-1:0]         req_i,
    input  logic [num_ports-1:0]         gnt_comb_i,
    input  logic [num_ports-1:0]         done_i,
    output logic [num_ports-1:0]         gnt_o,
    output logic                         gnt_valid_o,
    output logic [$clog2(num_ports)-1:0] gnt_idx_o,
    output logic                         timeout_o
);

    localparam int IDX_W = $clog2(num_ports);

    // Reject out-of-range configurations at elaboration.
    generate
        if (num_ports < 2 || num_ports > 32 || max_hold < 2 || max_hold > 65535) begin : g_param_err
            $error("grant_lock_ctrl: num_ports or max_hold out of range");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [num_ports-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [num_ports-1:0] low_mask;
    logic [IDX_W-1:0]     low_idx;
    logic                 owner_release;

    // Malformed arbiter output collapses to its lowest (highest-priority) bit.
    onehot_to_idx #(.N(num_ports)) u_enc (
        .in_i   (gnt_comb_i),
        .mask_o (low_mask),
        .idx_o  (low_idx)
    );

    // Only the owner's request and done bits matter; gnt_q masks the rest.
    assign owner_release = ~(|(gnt_q & req_i)) | (|(gnt_q & done_i));

`ifdef GNT_TIMEOUT_EN
    localparam int HOLD_W = $clog2(max_hold + 1);

    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              hold_expired;

    assign hold_expired = (cnt_q == HOLD_W'(max_hold - 1));

    // Next-state: capture in IDLE, hold in BUSY until release or hold expiry.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt_comb_i) begin
                    state_d = BUSY;
                    gnt_d   = low_mask;
                    idx_d   = low_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (owner_release) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end else if (hold_expired) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    idx_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Next-state: capture in IDLE, hold in BUSY until the owner releases.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|gnt_comb_i) begin
                    state_d = BUSY;
                    gnt_d   = low_mask;
                    idx_d   = low_idx;
                end
            end
            BUSY: begin
                if (owner_release) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == BUSY);
    assign gnt_idx_o   = idx_q;

endmodule : grant_lock_ctrl
